// File: rtl/rpn_kip_to_network_bridge_merger_if.sv
// rpn_kip_to_network_bridge_merger_if: AXIS stream bundle between the KIP engines, the merger and the network bridge
interface rpn_kip_to_network_bridge_merger_if #(
    parameter int DATA_WIDTH  = 512,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int TDEST_WIDTH = 8,
    parameter int TUSER_WIDTH = 64
);
    logic                   tvalid;
    logic                   tready;
    logic [DATA_WIDTH-1:0]  tdata;
    logic [KEEP_WIDTH-1:0]  tkeep;
    logic [TDEST_WIDTH-1:0] tid;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tlast;

    modport master (output tvalid, tdata, tkeep, tid, tdest, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tid, tdest, tuser, tlast, output tready);
endinterface

// File: rtl/rpn_kip_to_network_bridge_merger.sv
// rpn_kip_to_network_bridge_merger: packet-atomic round-robin merge of KIP TX/RX streams into a 2-deep registered FIFO
module rpn_kip_to_network_bridge_merger #(
    parameter int AXIS_DATA_WIDTH        = 512,
    parameter int AXIS_KEEP_WIDTH        = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_TO_NB_TDEST_WIDTH = 8,
    parameter int AXIS_TO_NB_TUSER_WIDTH = 64,
    parameter int PKT_CNT_WIDTH          = 16
) (
    input  logic                     i_clk,
    input  logic                     i_ap_rst_n,
    rpn_kip_to_network_bridge_merger_if.slave  from_rpn_kip_tx,
    rpn_kip_to_network_bridge_merger_if.slave  from_rpn_kip_rx,
    rpn_kip_to_network_bridge_merger_if.master to_network_bridge,
    output logic [PKT_CNT_WIDTH-1:0] o_tx_pkt_count,
    output logic [PKT_CNT_WIDTH-1:0] o_rx_pkt_count
);
    localparam int BW = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 2 * AXIS_TO_NB_TDEST_WIDTH + AXIS_TO_NB_TUSER_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, LOCK_TX, LOCK_RX} state_t;

    state_t          state;
    logic            prio;
    logic [1:0]      fifo_count;
    logic [BW-1:0]   head;
    logic [BW-1:0]   tail;
    logic [BW-1:0]   in_beat;
    logic            grant_tx;
    logic            grant_rx;
    logic            room;
    logic            acc_tx;
    logic            acc_rx;
    logic            push;
    logic            pop;

    always_comb begin
        grant_tx = state == LOCK_TX || (state == IDLE && from_rpn_kip_tx.tvalid && (!from_rpn_kip_rx.tvalid || !prio));
        grant_rx = state == LOCK_RX || (state == IDLE && from_rpn_kip_rx.tvalid && (!from_rpn_kip_tx.tvalid || prio));
        // Reset gating keeps both treadys low while the block is held in reset
        room     = i_ap_rst_n && fifo_count < 2'd2;
        acc_tx   = from_rpn_kip_tx.tvalid && grant_tx && room;
        acc_rx   = from_rpn_kip_rx.tvalid && grant_rx && room;
        push     = acc_tx || acc_rx;
        pop      = to_network_bridge.tvalid && to_network_bridge.tready;
        in_beat  = grant_rx ? {from_rpn_kip_rx.tdata, from_rpn_kip_rx.tkeep, from_rpn_kip_rx.tid,
                               from_rpn_kip_rx.tdest, from_rpn_kip_rx.tuser, from_rpn_kip_rx.tlast}
                            : {from_rpn_kip_tx.tdata, from_rpn_kip_tx.tkeep, from_rpn_kip_tx.tid,
                               from_rpn_kip_tx.tdest, from_rpn_kip_tx.tuser, from_rpn_kip_tx.tlast};
    end

    assign from_rpn_kip_tx.tready  = grant_tx && room;
    assign from_rpn_kip_rx.tready  = grant_rx && room;
    assign to_network_bridge.tvalid = fifo_count != 2'd0;
    assign {to_network_bridge.tdata, to_network_bridge.tkeep, to_network_bridge.tid,
            to_network_bridge.tdest, to_network_bridge.tuser, to_network_bridge.tlast} = head;

    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            state          <= IDLE;
            prio           <= 1'b0;
            o_tx_pkt_count <= '0;
            o_rx_pkt_count <= '0;
        end else if (acc_tx) begin
            state          <= from_rpn_kip_tx.tlast ? IDLE : LOCK_TX;
            prio           <= from_rpn_kip_tx.tlast ? 1'b1 : prio;
            o_tx_pkt_count <= o_tx_pkt_count + PKT_CNT_WIDTH'(from_rpn_kip_tx.tlast);
        end else if (acc_rx) begin
            state          <= from_rpn_kip_rx.tlast ? IDLE : LOCK_RX;
            prio           <= from_rpn_kip_rx.tlast ? 1'b0 : prio;
            o_rx_pkt_count <= o_rx_pkt_count + PKT_CNT_WIDTH'(from_rpn_kip_rx.tlast);
        end
    end

    // head is the registered output slot; tail holds the second entry
    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            fifo_count <= 2'd0;
            head       <= '0;
            tail       <= '0;
        end else begin
            if (push && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop)))
                head <= in_beat;
            else if (pop && fifo_count == 2'd2)
                head <= tail;
            if (push && (fifo_count == 2'd2 || (fifo_count == 2'd1 && !pop)))
                tail <= in_beat;
            fifo_count <= fifo_count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_rpn_kip_to_network_bridge_merger.sv
// tb_rpn_kip_to_network_bridge_merger: randomized and directed checks of the KIP merger against a queue-based model
module tb_rpn_kip_to_network_bridge_merger;
    localparam int DW = 512, KW = 64, IW = 8, UW = 64;
    // Narrow counters so the wrap is reached in a few thousand packets
    localparam int CW = 12;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [IW-1:0] id;
        logic [IW-1:0] dest;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;
    localparam int BW = $bits(beat_t);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rpn_kip_to_network_bridge_merger_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TDEST_WIDTH(IW), .TUSER_WIDTH(UW)) tx_if ();
    rpn_kip_to_network_bridge_merger_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TDEST_WIDTH(IW), .TUSER_WIDTH(UW)) rx_if ();
    rpn_kip_to_network_bridge_merger_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TDEST_WIDTH(IW), .TUSER_WIDTH(UW)) nb_if ();

    logic [CW-1:0] tx_cnt, rx_cnt;

    rpn_kip_to_network_bridge_merger #(
        .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_TO_NB_TDEST_WIDTH(IW),
        .AXIS_TO_NB_TUSER_WIDTH(UW), .PKT_CNT_WIDTH(CW)
    ) dut (
        .i_clk(clk), .i_ap_rst_n(rst_n),
        .from_rpn_kip_tx(tx_if), .from_rpn_kip_rx(rx_if), .to_network_bridge(nb_if),
        .o_tx_pkt_count(tx_cnt), .o_rx_pkt_count(rx_cnt)
    );

    beat_t tx_drv, rx_drv, tx_bus, rx_bus, nb_bus;
    assign {tx_if.tdata, tx_if.tkeep, tx_if.tid, tx_if.tdest, tx_if.tuser, tx_if.tlast} = tx_drv;
    assign {rx_if.tdata, rx_if.tkeep, rx_if.tid, rx_if.tdest, rx_if.tuser, rx_if.tlast} = rx_drv;
    assign tx_bus = {tx_if.tdata, tx_if.tkeep, tx_if.tid, tx_if.tdest, tx_if.tuser, tx_if.tlast};
    assign rx_bus = {rx_if.tdata, rx_if.tkeep, rx_if.tid, rx_if.tdest, rx_if.tuser, rx_if.tlast};
    assign nb_bus = {nb_if.tdata, nb_if.tkeep, nb_if.tid, nb_if.tdest, nb_if.tuser, nb_if.tlast};

    beat_t tx_q[$], rx_q[$], exp_q[$], out_log[$];
    int owner = -1, nxt = 0;
    int unsigned m_tx_cnt = 0, m_rx_cnt = 0;
    int checks = 0, errors = 0;
    int tx_pct = 0, rx_pct = 0, ds_pct = 100;
    bit acc_tx = 0, acc_rx = 0, g_tx, g_rx, room;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the output is the sequence of accepted input beats, buffered in at most two slots
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            owner = -1; nxt = 0; m_tx_cnt = 0; m_rx_cnt = 0; acc_tx = 0; acc_rx = 0;
        end else begin
            room = exp_q.size() < 2;
            g_tx = owner == 0 || (owner < 0 && tx_if.tvalid && (!rx_if.tvalid || nxt == 0));
            g_rx = owner == 1 || (owner < 0 && rx_if.tvalid && (!tx_if.tvalid || nxt == 1));
            chk("tx_tready", tx_if.tready, g_tx && room);
            chk("rx_tready", rx_if.tready, g_rx && room);
            chk("out_tvalid", nb_if.tvalid, exp_q.size() != 0);
            if (exp_q.size() != 0) chk("out_payload", nb_bus, exp_q[0]);
            chk("tx_count", tx_cnt, CW'(m_tx_cnt));
            chk("rx_count", rx_cnt, CW'(m_rx_cnt));
            acc_tx = tx_if.tvalid && tx_if.tready;
            acc_rx = rx_if.tvalid && rx_if.tready;
            if (nb_if.tvalid && nb_if.tready) begin
                out_log.push_back(nb_bus);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (acc_tx) begin
                exp_q.push_back(tx_bus);
                if (tx_bus.last) begin owner = -1; nxt = 1; m_tx_cnt++; end else owner = 0;
            end
            if (acc_rx) begin
                exp_q.push_back(rx_bus);
                if (rx_bus.last) begin owner = -1; nxt = 0; m_rx_cnt++; end else owner = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
        if (acc_tx && tx_q.size() != 0) void'(tx_q.pop_front());
        if (acc_rx && rx_q.size() != 0) void'(rx_q.pop_front());
        tx_if.tvalid = tx_q.size() != 0 && $urandom_range(99) < tx_pct;
        rx_if.tvalid = rx_q.size() != 0 && $urandom_range(99) < rx_pct;
        tx_drv = tx_q.size() != 0 ? tx_q[0] : '0;
        rx_drv = rx_q.size() != 0 ? rx_q[0] : '0;
        nb_if.tready = $urandom_range(99) < ds_pct;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((tx_q.size() != 0 || rx_q.size() != 0 || exp_q.size() != 0) && n < max) begin
            step();
            n++;
        end
        chk("drain_timeout", n < max, 1'b1);
    endtask

    function automatic beat_t mkb(input int src, input logic [31:0] d, input bit last);
        beat_t b = '0;
        b.data = DW'(d);
        b.keep = '1;
        b.id   = IW'(src);
        b.last = last;
        return b;
    endfunction

    function automatic beat_t logged(input int i);
        return i < out_log.size() ? out_log[i] : '1;
    endfunction

    task automatic add_pkt(input int src, input int len);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.data = {16{$urandom}};
            b.keep = {2{$urandom}};
            b.id   = IW'(src);
            b.dest = IW'($urandom);
            b.user = {2{$urandom}};
            b.last = i == len - 1;
            if (src == 0) tx_q.push_back(b); else rx_q.push_back(b);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        tx_q.delete(); rx_q.delete();
        tx_if.tvalid = 1'b1; rx_if.tvalid = 1'b1;
        #1;
        chk("rst_out_tvalid", nb_if.tvalid, 1'b0);
        chk("rst_tx_tready", tx_if.tready, 1'b0);
        chk("rst_rx_tready", rx_if.tready, 1'b0);
        chk("rst_payload", nb_bus, '0);
        chk("rst_tx_count", tx_cnt, '0);
        chk("rst_rx_count", rx_cnt, '0);
        repeat (2) @(posedge clk);
        #1;
        tx_if.tvalid = 1'b0; rx_if.tvalid = 1'b0; tx_drv = '0; rx_drv = '0;
        out_log.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        tx_if.tvalid = 1'b0; rx_if.tvalid = 1'b0; nb_if.tready = 1'b1; tx_drv = '0; rx_drv = '0;
        do_reset();

        tx_pct = 100; rx_pct = 100; ds_pct = 100;
        tx_q.push_back(mkb(0, 32'h11, 0)); tx_q.push_back(mkb(0, 32'h22, 0)); tx_q.push_back(mkb(0, 32'h33, 1));
        drain(100);
        chk("single_len", out_log.size(), 3);
        chk("single_b0", logged(0).data, 32'h11);
        chk("single_b1", logged(1).data, 32'h22);
        chk("single_b2", logged(2).data, 32'h33);
        chk("single_last", logged(2).last, 1'b1);
        chk("single_tx_count", tx_cnt, 1);

        do_reset();
        tx_q.push_back(mkb(0, 32'hA0, 0)); tx_q.push_back(mkb(0, 32'hA1, 1));
        rx_q.push_back(mkb(1, 32'hB0, 0)); rx_q.push_back(mkb(1, 32'hB1, 1));
        drain(100);
        chk("simul_b0", logged(0).data, 32'hA0);
        chk("simul_b1", logged(1).data, 32'hA1);
        chk("simul_b2", logged(2).data, 32'hB0);
        chk("simul_b3", logged(3).data, 32'hB1);
        chk("simul_counts", {tx_cnt, rx_cnt}, {CW'(1), CW'(1)});

        do_reset();
        for (int i = 0; i < 4; i++) begin
            tx_q.push_back(mkb(0, 32'h100 + i, 1));
            rx_q.push_back(mkb(1, 32'h200 + i, 1));
        end
        drain(100);
        for (int i = 0; i < 8; i++) chk($sformatf("rr_src%0d", i), logged(i).id, IW'(i % 2));
        chk("rr_counts", {tx_cnt, rx_cnt}, {CW'(4), CW'(4)});

        do_reset();
        for (int i = 0; i < 4; i++) rx_q.push_back(mkb(1, 32'hC0 + i, i == 3));
        ds_pct = 0;
        repeat (5) step();
        chk("bp_rx_tready", rx_if.tready, 1'b0);
        chk("bp_out_tvalid", nb_if.tvalid, 1'b1);
        chk("bp_hold", nb_bus.data, 32'hC0);
        ds_pct = 100;
        drain(100);
        chk("bp_len", out_log.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("bp_b%0d", i), logged(i).data, 32'hC0 + i);

        do_reset();
        for (int i = 0; i < 3; i++) tx_q.push_back(mkb(0, 32'hD0 + i, i == 2));
        rx_q.push_back(mkb(1, 32'hE0, 1));
        step();
        tx_pct = 0;
        repeat (3) begin
            step();
            chk("lock_rx_tready", rx_if.tready, 1'b0);
        end
        tx_pct = 100;
        drain(100);
        chk("lock_b0", logged(0).data, 32'hD0);
        chk("lock_b2", logged(2).data, 32'hD2);
        chk("lock_b3", logged(3).data, 32'hE0);

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                tx_pct = $urandom_range(20, 100);
                rx_pct = $urandom_range(20, 100);
                ds_pct = $urandom_range(0, 100);
            end
            if (tx_q.size() < 4 && $urandom_range(3) == 0) add_pkt(0, $urandom_range(1, 4));
            if (rx_q.size() < 4 && $urandom_range(3) == 0) add_pkt(1, $urandom_range(1, 4));
            step();
        end
        ds_pct = 100; tx_pct = 100; rx_pct = 100;
        drain(2000);

        do_reset();
        tx_q.push_back(mkb(0, 32'hF0, 1));
        for (int i = 1; i <= 4; i++) tx_q.push_back(mkb(0, 32'hF0 + i, i == 4));
        repeat (4) step();
        chk("pre_rst_tx_count", tx_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_tvalid", nb_if.tvalid, 1'b0);
        chk("mid_rst_tx_tready", tx_if.tready, 1'b0);
        chk("mid_rst_rx_tready", rx_if.tready, 1'b0);
        chk("mid_rst_tx_count", tx_cnt, '0);
        tx_q.delete();
        tx_if.tvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_log.delete();
        rx_q.push_back(mkb(1, 32'h99, 1));
        drain(100);
        chk("post_rst_len", out_log.size(), 1);
        chk("post_rst_b0", logged(0).data, 32'h99);

        do_reset();
        for (int i = 0; i < (1 << CW); i++) tx_q.push_back(mkb(0, i, 1));
        drain((1 << CW) + 100);
        chk("wrap_len", out_log.size(), 1 << CW);
        chk("wrap_tx_count", tx_cnt, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
